// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
//
// UART receiver / deserializer. It oversamples the serial line with an
// external tick running at N_TICKS x baud. It aligns to the middle of the
// start bit and then samples every data bit (LSB first), the optional parity
// bit and the stop bit at their centres.
//
// Optional feature (compile-time macro):
//   UART_RX_PARITY_EN  - adds a PARITY state after the data bits and checks
//                        even parity over data + parity bit. Without the
//                        macro the frame is 8N1 and o_parity_err is tied to 0.
//
// Parameters:
//   NB_DATA      data bits per frame (default 8)
//   N_TICKS      oversampling ticks per bit period; must be even and >= 4
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_reset      synchronous active-high reset
//   i_tick       one-cycle pulse at N_TICKS x baud (may be high on
//                consecutive cycles)
//   i_rx         asynchronous serial line, idles high
//   o_data       last correctly received data word
//   o_rx_done    one-cycle pulse, o_data was updated this cycle
//   o_frame_err  one-cycle pulse, the stop bit was sampled low
//   o_parity_err one-cycle pulse, parity mismatch with a valid stop bit
//   o_busy       high whenever the receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_deser #(
    parameter int NB_DATA = 8,
    parameter int N_TICKS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err,
    output logic               o_busy
);

    // -------------------------------------------------------------------------
    // Counter widths and compare points
    // -------------------------------------------------------------------------
    localparam int S_W = $clog2(N_TICKS);
    localparam int N_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    // Half a bit period after the falling edge lands in the middle of the
    // start bit; every later sample is a full bit period after that.
    localparam logic [S_W-1:0] S_MID  = S_W'(N_TICKS / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(N_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic               rx_meta_q;
    logic               rx_sync_q;

    state_e             state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;

    logic [NB_DATA-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;

`ifdef UART_RX_PARITY_EN
    logic               par_q, par_d;
    logic               perr_q, perr_d;
`endif

    // Centre of the stop bit: the single point where a frame is resolved.
    logic stop_sample;
    logic parity_ok;

    assign stop_sample = (state_q == ST_STOP) && i_tick && (s_q == S_LAST);

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus the parity bit must hold an even number of 1s.
    assign parity_ok = ~(^{shreg_q, par_q});
`else
    assign parity_ok = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Process 1: state register (includes the input synchronizer)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // The synchronizer resets to the idle line level so that leaving
            // reset never looks like a falling edge.
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= ST_IDLE;
            s_q       <= '0;
            n_q       <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state and datapath logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // The start edge is taken on any cycle, with or without a tick.
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end

            ST_START: begin
                if (i_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_sync_q) begin
                            state_d = ST_DATA;
                            n_d     = '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        // LSB arrives first, so shift in from the top.
                        shreg_d = {rx_sync_q, shreg_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        par_d   = rx_sync_q;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        // A low stop bit may be the start of a break; wait for
                        // the line to return high so it reports only once.
                        state_d = rx_sync_q ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            ST_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: output logic
    // -------------------------------------------------------------------------
    // The three status pulses are decided at the stop-bit sample and
    // registered. A frame error wins over a parity error, so at most one pulse
    // fires per frame.
    always_comb begin
        data_d = data_q;
        done_d = 1'b0;
        ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d = 1'b0;
`endif

        if (stop_sample) begin
            if (!rx_sync_q) begin
                ferr_d = 1'b1;
            end else if (!parity_ok) begin
`ifdef UART_RX_PARITY_EN
                perr_d = 1'b1;
`endif
            end else begin
                done_d = 1'b1;
                data_d = shreg_q;
            end
        end

        o_busy = (state_q != ST_IDLE);
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;

`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
//
// Directed bench for uart_rx_deser (NB_DATA=8, N_TICKS=16). A serial driver
// builds frames bit by bit. Each frame pushes its expected outcome into a
// scoreboard queue, and a monitor pops and compares whenever the DUT pulses an
// output. Build with UART_RX_PARITY_EN defined to include the parity steps.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser;

    localparam int NB_DATA = 8;
    localparam int N_TICKS = 16;

    typedef enum int {EV_DONE = 0, EV_FERR = 1, EV_PERR = 2} ev_e;

    typedef struct {
        ev_e        kind;
        logic [7:0] data;
    } exp_t;

    logic               clk;
    logic               i_reset;
    logic               i_tick;
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;
    logic               o_parity_err;
    logic               o_busy;

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   tick_div = 1;
    exp_t exp_q[$];

    uart_rx_deser #(
        .NB_DATA (NB_DATA),
        .N_TICKS (N_TICKS)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance k oversampling ticks; one tick every tick_div cycles
    // (tick_div=1 keeps i_tick high on consecutive cycles).
    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            for (int j = 1; j < tick_div; j++) begin
                i_tick = 1'b0;
                @(negedge clk);
            end
            i_tick = 1'b1;
            @(negedge clk);
        end
        i_tick = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        ticks(N_TICKS);
    endtask

    task automatic push_exp(input ev_e kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Frame with a correct parity bit when parity is enabled.
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < NB_DATA; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < NB_DATA; i++) send_bit(d[i]);
        send_bit(par_b);
        send_bit(1'b1);
    endtask
`endif

    // Wait (bounded) until every expected event has been seen by the monitor.
    task automatic drain(input string tag);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (o_rx_done === 1'b1 || o_frame_err === 1'b1 || o_parity_err === 1'b1) begin
            int   kind;
            exp_t e;
            kind = o_rx_done ? EV_DONE : (o_frame_err ? EV_FERR : EV_PERR);
            if (o_rx_done) done_cnt++;
            check("pulse_onehot", $onehot({o_rx_done, o_frame_err, o_parity_err}), 1);
            check("unexpected_pulse", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                if (e.kind == EV_DONE) check("rx_data", o_data, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_before;

        i_reset = 1'b1;
        i_tick  = 1'b0;
        i_rx    = 1'b1;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_data",  o_data,       0);
        check("reset_busy",  o_busy,       0);
        check("reset_done",  o_rx_done,    0);
        check("reset_ferr",  o_frame_err,  0);
        check("reset_perr",  o_parity_err, 0);

        // Single frame 0x5A
        tick_div = 3;
        ticks(20);
        push_exp(EV_DONE, 8'h5A);
        done_before = done_cnt;
        send_frame(8'h5A, 1'b1);
        ticks(8);
        drain("drain_5a");
        check("data_5a",  o_data, 8'h5A);
        check("done_cnt_5a", done_cnt - done_before, 1);
        check("busy_5a",  o_busy, 0);

        // 4-tick glitch on the line: rejected, no pulse
        i_rx = 1'b0;
        ticks(4);
        i_rx = 1'b1;
        ticks(40);
        check("glitch_busy", o_busy, 0);
        check("glitch_data", o_data, 8'h5A);
        drain("drain_glitch");

        // 0xFF with low stop bit, then a break of 3 frame times
        tick_div = 2;
        push_exp(EV_FERR, 8'h00);
        send_frame(8'hFF, 1'b0);
        i_rx = 1'b0;
        ticks(3 * 10 * N_TICKS);
        check("break_busy", o_busy, 1);
        drain("drain_break");
        check("break_data", o_data, 8'h5A);
        i_rx = 1'b1;
        ticks(N_TICKS);
        check("break_idle", o_busy, 0);
        push_exp(EV_DONE, 8'h81);
        send_frame(8'h81, 1'b1);
        ticks(8);
        drain("drain_81");
        check("data_81", o_data, 8'h81);

        // Back-to-back frames with ticks on every cycle
        tick_div = 1;
        ticks(N_TICKS);
        push_exp(EV_DONE, 8'h00);
        push_exp(EV_DONE, 8'hFF);
        done_before = done_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        ticks(8);
        drain("drain_b2b");
        check("b2b_done_cnt", done_cnt - done_before, 2);
        check("data_b2b", o_data, 8'hFF);

        // Reset after data bit 3 of 0xA5: partial frame is discarded
        tick_div = 2;
        ticks(N_TICKS);
        begin
            logic [7:0] partial;
            partial = 8'hA5;
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(partial[i]);
        end
        i_rx    = 1'b1;
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_data", o_data, 0);
        check("midreset_busy", o_busy, 0);
        i_reset = 1'b0;
        ticks(20);
        check("postreset_busy", o_busy, 0);
        push_exp(EV_DONE, 8'h3C);
        send_frame(8'h3C, 1'b1);
        ticks(8);
        drain("drain_3c");
        check("data_3c", o_data, 8'h3C);

`ifdef UART_RX_PARITY_EN
        // 0x03 has even weight: parity bit 1 is a mismatch, 0 is correct
        tick_div = 1;
        ticks(N_TICKS);
        push_exp(EV_PERR, 8'h00);
        send_frame_par(8'h03, 1'b1);
        ticks(8);
        drain("drain_perr");
        check("perr_data", o_data, 8'h3C);
        push_exp(EV_DONE, 8'h03);
        send_frame_par(8'h03, 1'b0);
        ticks(8);
        drain("drain_par_ok");
        check("par_ok_data", o_data, 8'h03);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame.
REQ-002 Parameter N_TICKS, default 16, oversampling ticks per bit period; SHALL be even and at least 4.
REQ-003 i_clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 i_tick  input  1  one-cycle pulse at N_TICKS x baud, supplied by the baud-rate generator.
REQ-006 i_rx  input  1  asynchronous serial line; idles high.
REQ-007 o_data  output  NB_DATA  last correctly received byte.
REQ-008 o_rx_done  output  1  one-cycle pulse; o_data was updated this cycle.
REQ-009 o_frame_err  output  1  one-cycle pulse; the stop bit was sampled low.
REQ-010 o_parity_err  output  1  one-cycle pulse; parity mismatch (see Configuration).
REQ-011 o_busy  output  1  high in every state except IDLE.

Function
REQ-012 i_rx SHALL pass through a 2-FF synchronizer (reset value 1) before any use; input latency is 2 cycles.
REQ-013 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP and WAIT_HIGH.
REQ-014 Tick counter s (0..N_TICKS-1) and bit counter n (0..NB_DATA-1) SHALL change only on cycles with i_tick=1, except when cleared on a state transition.
REQ-015 IDLE: synchronized rx=0 -> START with s=0, regardless of i_tick.
REQ-016 START: on the tick where s=N_TICKS/2-1, rx=0 -> DATA with s=0 and n=0; rx=1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: on the tick where s=N_TICKS-1, shift rx into the MSB of the shift register (LSB first on the line) and set s=0; n=NB_DATA-1 -> PARITY if the macro is defined, else STOP; otherwise n+1.
REQ-018 STOP: on the tick where s=N_TICKS-1, rx=1 with no parity error -> o_data<=shift register, o_rx_done=1, go to IDLE.
REQ-019 STOP, rx=0 -> o_frame_err=1, o_data unchanged, go to WAIT_HIGH; the frame error takes precedence over a parity error.
REQ-020 WAIT_HIGH: stay until synchronized rx=1, then go to IDLE; a held-low line (break) SHALL produce exactly one o_frame_err.
REQ-021 o_rx_done, o_frame_err and o_parity_err SHALL be mutually exclusive, and each SHALL be high for at most one cycle per frame.
REQ-022 Back-to-back frames SHALL be received with no extra idle time: a start edge in the cycle after STOP completes is accepted.
REQ-023 i_tick arriving on consecutive cycles SHALL be handled; no tick is lost.

Reset
REQ-024 i_reset=1 SHALL force IDLE, s=0, n=0, shift register=0, o_data=0, o_rx_done=0, o_frame_err=0, o_parity_err=0, o_busy=0 and synchronizer=1, on the next edge.
REQ-025 Reset mid-frame SHALL discard the partial byte and SHALL NOT produce any output pulse.
REQ-026 After reset is released, reception SHALL start only from a fresh falling edge seen in IDLE.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: after the data bits, the PARITY state samples one bit at s=N_TICKS-1 and checks even parity over data plus parity bit.
REQ-028 With the macro, a mismatch with a valid stop bit SHALL give o_parity_err=1, o_rx_done=0 and o_data unchanged.
REQ-029 Macro undefined: the PARITY state and its logic are absent, the frame is 8N1, and o_parity_err SHALL be tied to 0 (port retained).

Verification
REQ-030 8N1, N_TICKS=16, send 0x5A -> o_data=0x5A, exactly one o_rx_done pulse, o_busy low afterwards.
REQ-031 Low pulse on i_rx lasting 4 ticks -> no pulse on any output, FSM back in IDLE, o_data unchanged.
REQ-032 Send 0xFF with stop bit low, then hold the line low for 3 frame times -> exactly one o_frame_err pulse; the next 0x81 sent after the line goes high -> o_data=0x81.
REQ-033 Send 0x00 and 0xFF back-to-back with zero idle time -> two o_rx_done pulses, with o_data=0x00 and then 0xFF.
REQ-034 Assert i_reset after data bit 3 of 0xA5, then send 0x3C -> no pulse for the aborted frame; o_data=0x3C.
REQ-035 UART_RX_PARITY_EN defined: 0x03 with parity bit 1 -> o_parity_err pulse, o_rx_done=0; 0x03 with parity bit 0 -> o_rx_done pulse with o_data=0x03.
